dot_product_engine: RTL and testbench

//  Streaming multi-lane dot-product engine, successor to the single-lane dotProduct block.

---
 rtl/dot_product_pkg.sv | 25 ++
 rtl/dp_adder_tree.sv | 39 +++
 rtl/dot_product_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_dot_product_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the dot-product engine.
package dot_product_pkg;

   // Accumulator FSM: waiting for the first beat of a vector, or mid-vector
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Result width: full product, plus growth from the lane sum and the beat count
   function automatic int acc_width(input int data_width, input int lanes, input int max_beats);
      return 2*data_width + $clog2(lanes) + $clog2(max_beats);
   endfunction

   // Beat counter must be able to hold MAX_BEATS itself
   function automatic int cnt_width(input int max_beats);
      return $clog2(max_beats + 1);
   endfunction

   // LSB position of a lane inside a flattened lane bus (lane 0 in the LSBs)
   function automatic int lane_lo(input int lane, input int data_width);
      return lane * data_width;
   endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// Registered adder tree: extends LANES products to the result width by mode and sums them.
module dp_adder_tree
   import dot_product_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, LANES, 16)
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 mode,
   input  logic [LANES-1:0][2*DATA_WIDTH-1:0]   prod,
   output logic [ACC_WIDTH-1:0]                 sum
);

   localparam int PW  = 2*DATA_WIDTH;
   localparam int EXT = ACC_WIDTH - PW;

   // Heap-ordered tree: node 0 is the root, leaves sit at LANES-1 .. 2*LANES-2
   logic [ACC_WIDTH-1:0] node [2*LANES-1];

   genvar gk;
   generate
      for (gk = 0; gk < LANES; gk++) begin : g_leaf
         assign node[LANES-1+gk] = mode ? {{EXT{prod[gk][PW-1]}}, prod[gk]}
                                        : {{EXT{1'b0}}, prod[gk]};
      end
      for (gk = 0; gk < LANES-1; gk++) begin : g_node
         assign node[gk] = node[2*gk+1] + node[2*gk+2];
      end
   endgenerate

   // S2: register the lane sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum <= '0;
      else        sum <= node[0];
   end

endmodule

// File: rtl/dot_product_engine.sv
// Streaming multi-lane dot-product engine with per-vector accumulation,
// credit-based input flow control and a 2-entry result buffer.
module dot_product_engine
   import dot_product_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int MAX_BEATS  = 16,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, LANES, MAX_BEATS),
   parameter int CNT_WIDTH  = cnt_width(MAX_BEATS)
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          signed_mode,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   s_a,
   input  logic [LANES*DATA_WIDTH-1:0]   s_b,
   input  logic                          s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [ACC_WIDTH-1:0]          m_result,
   output logic [CNT_WIDTH-1:0]          m_beats,
   output logic                          m_err
);

   localparam int STAGES = 3;
   localparam int PW     = 2*DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] BEATS_MAX = CNT_WIDTH'(MAX_BEATS);

   // ---------------- input side ----------------
   logic accept;
   logic beat_mode;
   logic in_mid;
   logic in_mode;

   // A beat offered during clear is dropped, never accepted
   assign accept    = s_valid & s_ready & ~clear;
   // Mode is taken from the first beat and held for the rest of the vector
   assign beat_mode = in_mid ? in_mode : signed_mode;

   // Track whether a vector is open on the input side and its latched mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_mid  <= 1'b0;
         in_mode <= 1'b0;
      end else if (clear) begin
         in_mid  <= 1'b0;
      end else if (accept) begin
         in_mid  <= ~s_last;
         in_mode <= beat_mode;
      end
   end

   // ---------------- pipeline ----------------
   logic [STAGES-1:0]                  vld_pipe;
   logic [STAGES-1:0]                  last_pipe;
   logic [STAGES-2:0]                  mode_pipe;
   logic [LANES-1:0][DATA_WIDTH-1:0]   a_q, b_q;
   logic [LANES-1:0][PW-1:0]           prod, prod_q;
   logic [ACC_WIDTH-1:0]               sum_q;

   // Control shift register; clear empties every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         mode_pipe <= '0;
      end else if (clear) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-2:0], accept};
         last_pipe <= {last_pipe[STAGES-2:0], accept & s_last};
         mode_pipe <= {mode_pipe[STAGES-3:0], beat_mode};
      end
   end

   // Capture accepted operand lanes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (accept) begin
         for (int k = 0; k < LANES; k++) begin
            a_q[k] <= s_a[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
            b_q[k] <= s_b[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

   // Per-lane multiply: extending operands to the product width makes the
   // low PW bits correct for both signed and unsigned interpretations
   genvar gl;
   generate
      for (gl = 0; gl < LANES; gl++) begin : g_mul
         logic [PW-1:0] ax, bx;
         assign ax       = {{DATA_WIDTH{mode_pipe[0] & a_q[gl][DATA_WIDTH-1]}}, a_q[gl]};
         assign bx       = {{DATA_WIDTH{mode_pipe[0] & b_q[gl][DATA_WIDTH-1]}}, b_q[gl]};
         assign prod[gl] = ax * bx;
      end
   endgenerate

   // S1: register lane products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_q <= '0;
      else        prod_q <= prod;
   end

   dp_adder_tree #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_tree (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode_pipe[STAGES-2]),
      .prod  (prod_q),
      .sum   (sum_q)
   );

   // ---------------- accumulator FSM ----------------
   acc_state_e            state;
   logic [ACC_WIDTH-1:0]  acc, acc_n;
   logic [CNT_WIDTH-1:0]  beats, beats_n;
   logic                  err, err_n;
   logic                  push;

   assign push = vld_pipe[STAGES-1] & last_pipe[STAGES-1] & ~clear;

   // Next accumulator values for the beat leaving the tree; a first beat restarts
   always_comb begin
      acc_n   = sum_q;
      beats_n = CNT_WIDTH'(1);
      err_n   = 1'b0;
      if (state == ACCUM) begin
         acc_n   = acc + sum_q;
         beats_n = beats;
         err_n   = err;
         if (beats == BEATS_MAX) err_n   = 1'b1;
         else                    beats_n = beats + CNT_WIDTH'(1);
      end
   end

   // S3: accumulate beats; a last beat hands its total to the buffer and rearms
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         beats <= '0;
         err   <= 1'b0;
      end else if (clear) begin
         state <= IDLE;
         acc   <= '0;
         beats <= '0;
         err   <= 1'b0;
      end else if (vld_pipe[STAGES-1]) begin
         acc   <= acc_n;
         beats <= beats_n;
         err   <= err_n;
         state <= last_pipe[STAGES-1] ? IDLE : ACCUM;
      end
   end

   // ---------------- result buffer ----------------
   logic [ACC_WIDTH-1:0]  f_res   [2];
   logic [CNT_WIDTH-1:0]  f_beats [2];
   logic                  f_err   [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            f_cnt, f_cnt_n;
   logic                  pop;

   assign pop = m_valid & m_ready;

   // Occupancy after this edge
   always_comb begin
      f_cnt_n = f_cnt;
      case ({push, pop})
         2'b10:   f_cnt_n = f_cnt + 2'd1;
         2'b01:   f_cnt_n = f_cnt - 2'd1;
         default: f_cnt_n = f_cnt;
      endcase
   end

   // Two-entry FIFO; outputs come straight from the head entry so they hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            f_res[i]   <= '0;
            f_beats[i] <= '0;
            f_err[i]   <= 1'b0;
         end
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         f_cnt   <= '0;
         m_valid <= 1'b0;
      end else begin
         if (push) begin
            f_res[wr_ptr]   <= acc_n;
            f_beats[wr_ptr] <= beats_n;
            f_err[wr_ptr]   <= err_n;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         f_cnt   <= f_cnt_n;
         m_valid <= (f_cnt_n != 2'd0);
      end
   end

   assign m_result = f_res[rd_ptr];
   assign m_beats  = f_beats[rd_ptr];
   assign m_err    = f_err[rd_ptr];

   // ---------------- credits ----------------
   logic [2:0] used_n;

   // Results that will be buffered or still owed after this edge
   always_comb begin
      used_n = 3'(f_cnt_n) + 3'(accept & s_last);
      if (!clear) begin
         for (int i = 0; i < STAGES-1; i++) used_n = used_n + 3'(last_pipe[i]);
      end
   end

   // Accept only while fewer than two results are owed, so none can be dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_ready <= 1'b0;
      else        s_ready <= (used_n < 3'd2);
   end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed table, corner sequences, random vectors.
module tb_dot_product_engine;

   localparam int DW = 8;
   localparam int L  = 4;
   localparam int MB = 16;
   localparam int AW = 22;
   localparam int CW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic            signed_mode = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [L*DW-1:0] s_a = '0;
   logic [L*DW-1:0] s_b = '0;
   logic            s_last = 1'b0;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic [AW-1:0]   m_result;
   logic [CW-1:0]   m_beats;
   logic            m_err;

   always #5 clk = ~clk;

   dot_product_engine #(.DATA_WIDTH(DW), .LANES(L), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .signed_mode(signed_mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
      .m_beats(m_beats), .m_err(m_err)
   );

   typedef struct {
      logic [AW-1:0] res;
      logic [CW-1:0] beats;
      logic          err;
   } res_t;

   typedef struct {
      logic [31:0]   a0, a1, b0, b1;
      int            nb;
      bit            mode;
      logic [AW-1:0] res;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   res_t        exp_q[$];
   res_t        got [512];
   int          got_n = 0;
   int          rd = 0;
   logic [31:0] va[$];
   logic [31:0] vb[$];
   bit          rnd_ready = 1'b0;
   vec_t        tbl [6];

   // Record every result handed over (pop happens at the next rising edge)
   always @(negedge clk) begin
      if (m_valid && m_ready && got_n < 512) begin
         got[got_n] <= '{m_result, m_beats, m_err};
         got_n      <= got_n + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Present one beat and return just after the edge that accepts it
   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit last, input bit mode);
      int g;
      s_valid = 1'b1; s_a = a; s_b = b; s_last = last; signed_mode = mode;
      g = 0;
      while (!s_ready && g < 500) begin
         tick();
         g++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: s_ready=0 after %0d cycles, want 1", g);
      end
      tick();
   endtask

   // Send va/vb as one vector; flip scrambles signed_mode after the first beat
   task automatic send_vec(input bit mode, input bit flip, input bit gaps);
      for (int i = 0; i < va.size(); i++) begin
         send_beat(va[i], vb[i], i == va.size()-1, (i == 0 || !flip) ? mode : 1'($urandom_range(0, 1)));
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Reference: plain integer dot product over all beats, reduced modulo 2^AW
   function automatic res_t model(input bit mode);
      res_t             r;
      longint           acc;
      longint           xa, xb;
      logic [31:0]      wa, wb;
      logic [7:0]       ea, eb;
      acc = 0;
      for (int i = 0; i < va.size(); i++) begin
         wa = va[i];
         wb = vb[i];
         for (int l = 0; l < L; l++) begin
            ea = wa[8*l +: 8];
            eb = wb[8*l +: 8];
            xa = mode ? longint'($signed(ea)) : longint'(ea);
            xb = mode ? longint'($signed(eb)) : longint'(eb);
            acc += xa * xb;
         end
      end
      r.res   = AW'(acc);
      r.beats = (va.size() > MB) ? CW'(MB) : CW'(va.size());
      r.err   = (va.size() > MB);
      return r;
   endfunction

   // Wait for every expected result, then compare in order
   task automatic drain();
      int   g;
      res_t e;
      g = 0;
      while ((got_n - rd) < exp_q.size() && g < 600) begin
         tick();
         g++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd < got_n) begin
            chk($sformatf("result[%0d]", rd), got[rd].res, e.res);
            chk($sformatf("beats[%0d]", rd), got[rd].beats, e.beats);
            chk($sformatf("err[%0d]", rd), got[rd].err, e.err);
            rd++;
         end else begin
            checks++;
            errors++;
            $display("FAIL missing_result: none received, want 0x%0h", e.res);
         end
      end
   endtask

   initial begin
      res_t r;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_result", m_result, 0);
      chk("rst_m_beats", m_beats, 0);
      chk("rst_m_err", m_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s_ready_before_first_edge", s_ready, 0);
      tick();
      chk("s_ready_after_first_edge", s_ready, 1);

      // ---- directed table, with first-result latency ----
      tbl[0] = '{32'h04030201, 32'h08070605, 32'h01010101, 32'h01010101, 2, 1'b0, 22'd36};
      tbl[1] = '{32'hFCFDFEFF, 32'h0,        32'h02020202, 32'h0,        1, 1'b1, 22'h3FFFEC};
      tbl[2] = '{32'hFCFDFEFF, 32'h0,        32'h02020202, 32'h0,        1, 1'b0, 22'd2028};
      tbl[3] = '{32'h7F7F7F7F, 32'h0,        32'h80808080, 32'h0,        1, 1'b1, 22'h3F0200};
      tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0, 22'd520200};
      tbl[5] = '{32'h00FF0180, 32'h0,        32'h00050302, 32'h0,        1, 1'b1, 22'h3FFEFE};
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         va.delete(); vb.delete();
         va.push_back(tbl[i].a0); vb.push_back(tbl[i].b0);
         if (tbl[i].nb == 2) begin
            va.push_back(tbl[i].a1); vb.push_back(tbl[i].b1);
         end
         exp_q.push_back('{tbl[i].res, CW'(tbl[i].nb), 1'b0});
         send_vec(tbl[i].mode, 1'b0, 1'b0);
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_early_valid_%0d", i, j), m_valid, 0);
         end
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_at_n3", i), m_valid, 1);
         drain();
      end

      // ---- backpressure: three single-beat vectors, consumer stalled ----
      m_ready = 1'b0;
      va = '{32'h01010101}; vb = '{32'h02020202};
      exp_q.push_back('{22'd8, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      chk("bp_ready_after_1", s_ready, 1);
      va = '{32'h03030303}; vb = '{32'h01010101};
      exp_q.push_back('{22'd12, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      chk("bp_ready_after_2", s_ready, 0);
      s_valid = 1'b1; s_a = 32'h05050505; s_b = 32'h01010101; s_last = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk($sformatf("bp_blocked_%0d", j), s_ready, 0);
         if (j >= 2) begin
            chk($sformatf("bp_hold_valid_%0d", j), m_valid, 1);
            chk($sformatf("bp_hold_result_%0d", j), m_result, 8);
         end
      end
      m_ready = 1'b1;
      va = '{32'h05050505}; vb = '{32'h01010101};
      exp_q.push_back('{22'd20, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      drain();

      // ---- overflow: 17 beats, then a normal vector with mode toggled mid-vector ----
      va.delete(); vb.delete();
      repeat (17) begin
         va.push_back(32'hFFFFFFFF); vb.push_back(32'hFFFFFFFF);
      end
      exp_q.push_back('{22'd227396, 5'd16, 1'b1});
      send_vec(1'b0, 1'b0, 1'b0);
      va = '{32'h80FF7F01, 32'hFE02FD03, 32'h7F807F80}; vb = '{32'hFF80017F, 32'h03FE02FD, 32'h80807F7F};
      exp_q.push_back(model(1'b1));
      send_vec(1'b1, 1'b1, 1'b0);
      drain();

      // ---- clear mid-vector with an earlier result buffered ----
      m_ready = 1'b0;
      va = '{32'h01010101}; vb = '{32'h04040404};
      exp_q.push_back('{22'd16, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      chk("clr_buffered_valid", m_valid, 1);
      send_beat(32'h05050505, 32'h05050505, 1'b0, 1'b0);
      s_valid = 1'b1; s_a = 32'h07070707; s_b = 32'h07070707; s_last = 1'b1; clear = 1'b1;
      tick();
      clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      va = '{32'h00000003}; vb = '{32'h00000003};
      exp_q.push_back('{22'd9, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      m_ready = 1'b1;
      drain();
      repeat (8) tick();
      chk("clr_no_extra", got_n, rd);

      // ---- random vectors, random consumer stalls ----
      rnd_ready = 1'b1;
      for (int v = 0; v < 30; v++) begin
         bit md;
         int n;
         n  = $urandom_range(1, 20);
         md = 1'($urandom_range(0, 1));
         va.delete(); vb.delete();
         for (int i = 0; i < n; i++) begin
            va.push_back($urandom); vb.push_back($urandom);
         end
         exp_q.push_back(model(md));
         send_vec(md, 1'b1, 1'b1);
      end
      rnd_ready = 1'b0;
      m_ready = 1'b1;
      drain();

      // ---- async reset mid-vector with a result buffered ----
      m_ready = 1'b0;
      va = '{32'h02020202}; vb = '{32'h03030303};
      send_vec(1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      chk("rst_buffered_valid", m_valid, 1);
      send_beat(32'h09090909, 32'h09090909, 1'b0, 1'b0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_m_result", m_result, 0);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_m_beats", m_beats, 0);
      tick();
      rst_n = 1'b1;
      m_ready = 1'b1;
      repeat (10) tick();
      chk("midrst_no_stale_valid", m_valid, 0);
      chk("midrst_no_stale_result", got_n, rd);
      va = '{32'h01020304}; vb = '{32'h01010101};
      exp_q.push_back('{22'd10, 5'd1, 1'b0});
      send_vec(1'b0, 1'b0, 1'b0);
      drain();

      repeat (5) tick();
      chk("final_no_extra", got_n, rd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
